// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle between the refill controller, the decoder/tag lookup and main memory.
// The master side is the refill controller.
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 4
);
    logic                          cache_en;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [3:0]                    hit_en;
    logic                          cpu_stall;
    logic                          mem_req_valid;
    logic                          mem_req_ready;
    logic [ADDR_WIDTH-1:0]         mem_req_addr;
    logic                          mem_rdata_valid;
    logic [DATA_WIDTH-1:0]         mem_rdata;
    logic [BEATS*DATA_WIDTH-1:0]   refill_line;
    logic                          read_main_memory_en;
    logic [ADDR_WIDTH-1:0]         addr_to_main_memory;
    logic [15:0]                   refill_cnt;

    modport master (
        input  cache_en, addr, hit_en, mem_req_ready, mem_rdata_valid, mem_rdata,
        output cpu_stall, mem_req_valid, mem_req_addr, refill_line,
               read_main_memory_en, addr_to_main_memory, refill_cnt
    );

    modport slave (
        output cache_en, addr, hit_en, mem_req_ready, mem_rdata_valid, mem_rdata,
        input  cpu_stall, mem_req_valid, mem_req_addr, refill_line,
               read_main_memory_en, addr_to_main_memory, refill_cnt
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: requests a line from main memory, assembles its beats,
// then commits the line to the tag/data RAMs with a one-cycle strobe.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_refill_ctrl_if.master bus
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(15);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_FILL, S_COMMIT, S_SETTLE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_line_addr;
    logic [CW-1:0]         r_cnt;
    logic [15:0]           r_refill_cnt;
    logic                  w_miss;
    logic                  w_beat;

    assign w_miss = bus.cache_en && (bus.hit_en == 4'b0000);
    assign w_beat = (r_state == S_FILL) && bus.mem_rdata_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_miss) w_state_next = S_REQ;
            S_REQ:    if (bus.mem_req_ready) w_state_next = S_FILL;
            S_FILL:   if (w_beat && r_cnt == LAST_BEAT) w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_SETTLE;
            S_SETTLE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_stall           = (r_state != S_IDLE) || w_miss;
        bus.mem_req_valid       = (r_state == S_REQ);
        bus.mem_req_addr        = (r_state == S_REQ) ? r_line_addr : '0;
        bus.read_main_memory_en = (r_state == S_COMMIT);
        bus.addr_to_main_memory = r_line_addr;
        bus.refill_cnt          = r_refill_cnt;
    end

    // The line address is captured only on the miss so the tag RAM sees a stable value
    // from the following cycle through COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_addr  <= '0;
            r_cnt        <= '0;
            r_refill_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && w_miss)
                r_line_addr <= bus.addr & LINE_MASK;
            if (r_state == S_REQ && bus.mem_req_ready)
                r_cnt <= '0;
            else if (w_beat)
                r_cnt <= r_cnt + CW'(1);
            if (r_state == S_COMMIT && r_refill_cnt != 16'hFFFF)
                r_refill_cnt <= r_refill_cnt + 16'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] r_word;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_word <= '0;
                else if (w_beat && r_cnt == CW'(gi))
                    r_word <= bus.mem_rdata;
            end
            assign bus.refill_line[gi*DATA_WIDTH +: DATA_WIDTH] = r_word;
        end
    endgenerate
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: latency, stalls, gaps, reset abort, saturation.
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_refill_ctrl_if bus ();
    cache_refill_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    always @(negedge clk) if (bus.read_main_memory_en === 1'b1) pulses++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full refill from IDLE with immediate accept and back-to-back beats; lookup inputs
    // are scrambled after the miss. Returns at the first IDLE cycle.
    task automatic run_refill(input logic [31:0] a, input logic [127:0] line,
                              output int stall_low);
        stall_low = 0;
        bus.cache_en = 1'b1; bus.addr = a; bus.hit_en = 4'b0000;
        bus.mem_req_ready = 1'b1; bus.mem_rdata_valid = 1'b0;
        step();
        if (bus.cpu_stall !== 1'b1) stall_low++;
        bus.cache_en = 1'b0; bus.hit_en = 4'b0010; bus.addr = 32'hFFFF_FFF0;
        step();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (bus.cpu_stall !== 1'b1) stall_low++;
            bus.mem_rdata_valid = 1'b1; bus.mem_rdata = line[32*b +: 32];
            step();
        end
        bus.mem_rdata_valid = 1'b0;
        if (bus.cpu_stall !== 1'b1) stall_low++;
        step();
        if (bus.cpu_stall !== 1'b1) stall_low++;
        step();
        bus.hit_en = 4'b0000;
        $display("refill addr=%h line=%h cnt=%0d", a, bus.refill_line, bus.refill_cnt);
    endtask

    task automatic test_reset();
        bus.cache_en = 1'b0; bus.addr = '0; bus.hit_en = 4'b0000;
        bus.mem_req_ready = 1'b0; bus.mem_rdata_valid = 1'b0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", bus.cpu_stall); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b want 0", bus.mem_req_valid); end
        n_cmp++; if (bus.mem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr got %h want 0", bus.mem_req_addr); end
        n_cmp++; if (bus.refill_line !== 128'h0) begin n_err++; $display("FAIL rst_line got %h want 0", bus.refill_line); end
        n_cmp++; if (bus.read_main_memory_en !== 1'b0) begin n_err++; $display("FAIL rst_rden got %b want 0", bus.read_main_memory_en); end
        n_cmp++; if (bus.addr_to_main_memory !== 32'h0) begin n_err++; $display("FAIL rst_a2m got %h want 0", bus.addr_to_main_memory); end
        n_cmp++; if (bus.refill_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt got %h want 0", bus.refill_cnt); end
        $display("reset done");
    endtask

    task automatic test_basic();
        int p0 = pulses;
        step();
        bus.cache_en = 1'b1; bus.addr = 32'h0000_1234; bus.hit_en = 4'b0000; bus.mem_req_ready = 1'b1;
        #1;  // cycle 0
        n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL basic_stall_c0 got %b want 1", bus.cpu_stall); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_c0 got %b want 0", bus.mem_req_valid); end
        step();  // cycle 1
        bus.cache_en = 1'b0;
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_c1 got %b want 1", bus.mem_req_valid); end
        n_cmp++; if (bus.mem_req_addr !== 32'h0000_1230) begin n_err++; $display("FAIL basic_req_addr got %h want 00001230", bus.mem_req_addr); end
        n_cmp++; if (bus.addr_to_main_memory !== 32'h0000_1230) begin n_err++; $display("FAIL basic_a2m_c1 got %h want 00001230", bus.addr_to_main_memory); end
        step();  // cycle 2
        bus.mem_req_ready = 1'b0;
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_c2 got %b want 0", bus.mem_req_valid); end
        bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h1111_1111; step();
        bus.mem_rdata = 32'h2222_2222; step();
        bus.mem_rdata = 32'h3333_3333; step();
        n_cmp++; if (bus.read_main_memory_en !== 1'b0) begin n_err++; $display("FAIL basic_rden_c5 got %b want 0", bus.read_main_memory_en); end
        bus.mem_rdata = 32'h4444_4444; step();  // cycle 6
        bus.mem_rdata_valid = 1'b0;
        n_cmp++; if (bus.read_main_memory_en !== 1'b1) begin n_err++; $display("FAIL basic_rden_c6 got %b want 1", bus.read_main_memory_en); end
        n_cmp++; if (bus.refill_line !== 128'h44444444_33333333_22222222_11111111) begin n_err++; $display("FAIL basic_line got %h want 44444444333333332222222211111111", bus.refill_line); end
        n_cmp++; if (bus.addr_to_main_memory !== 32'h0000_1230) begin n_err++; $display("FAIL basic_a2m_c6 got %h want 00001230", bus.addr_to_main_memory); end
        step();  // cycle 7
        n_cmp++; if (bus.read_main_memory_en !== 1'b0) begin n_err++; $display("FAIL basic_rden_c7 got %b want 0", bus.read_main_memory_en); end
        n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL basic_stall_c7 got %b want 1", bus.cpu_stall); end
        n_cmp++; if (bus.refill_cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt got %0d want 1", bus.refill_cnt); end
        step();  // cycle 8: lookup now hits
        bus.cache_en = 1'b1; bus.hit_en = 4'b0001;
        #1;
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL basic_stall_c8 got %b want 0", bus.cpu_stall); end
        n_cmp++; if (bus.addr_to_main_memory !== 32'h0000_1230) begin n_err++; $display("FAIL basic_a2m_idle got %h want 00001230", bus.addr_to_main_memory); end
        n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL basic_pulses got %0d want 1", pulses - p0); end
        bus.cache_en = 1'b0; bus.hit_en = 4'b0000;
        $display("basic refill line=%h", bus.refill_line);
    endtask

    task automatic test_req_wait_gaps();
        step();
        bus.cache_en = 1'b1; bus.addr = 32'h0000_5678; bus.hit_en = 4'b0000; bus.mem_req_ready = 1'b0;
        step();  // REQ
        bus.cache_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_5670) begin n_err++; $display("FAIL wait_req_%0d got valid=%b addr=%h want 1/00005670", i, bus.mem_req_valid, bus.mem_req_addr); end
            bus.mem_rdata_valid = (i == 2); bus.mem_rdata = 32'hDEAD_BEEF;
            step();
        end
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL wait_req_held got %b want 1", bus.mem_req_valid); end
        bus.mem_req_ready = 1'b1; bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hCAFE_BABE;
        step();  // FILL
        bus.mem_req_ready = 1'b0; bus.mem_rdata_valid = 1'b0;
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid_fill got %b want 0", bus.mem_req_valid); end
        for (int b = 0; b < 4; b++) begin
            step(); step();
            bus.mem_rdata_valid = 1'b1; bus.mem_rdata = {4{8'hA1 + 8'(b * 1)}};
            step();
            bus.mem_rdata_valid = 1'b0;
            if (b == 2) begin
                n_cmp++; if (bus.read_main_memory_en !== 1'b0) begin n_err++; $display("FAIL gap_early_commit got %b want 0", bus.read_main_memory_en); end
            end
        end
        n_cmp++; if (bus.read_main_memory_en !== 1'b1) begin n_err++; $display("FAIL gap_rden got %b want 1", bus.read_main_memory_en); end
        n_cmp++; if (bus.refill_line !== 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1) begin n_err++; $display("FAIL gap_line got %h want A4A4A4A4A3A3A3A3A2A2A2A2A1A1A1A1", bus.refill_line); end
        step(); step();
        n_cmp++; if (bus.refill_cnt !== 16'd2) begin n_err++; $display("FAIL gap_cnt got %0d want 2", bus.refill_cnt); end
        $display("gapped refill line=%h", bus.refill_line);
    endtask

    task automatic test_lookup_ignored();
        int p0 = pulses;
        int sl;
        run_refill(32'h0000_9A0C, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, sl);
        n_cmp++; if (sl !== 0) begin n_err++; $display("FAIL ign_stall_low got %0d want 0", sl); end
        n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL ign_pulses got %0d want 1", pulses - p0); end
        n_cmp++; if (bus.addr_to_main_memory !== 32'h0000_9A00) begin n_err++; $display("FAIL ign_a2m got %h want 00009A00", bus.addr_to_main_memory); end
        n_cmp++; if (bus.refill_line !== 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A) begin n_err++; $display("FAIL ign_line got %h", bus.refill_line); end
        n_cmp++; if (bus.refill_cnt !== 16'd3) begin n_err++; $display("FAIL ign_cnt got %0d want 3", bus.refill_cnt); end
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL ign_stall_idle got %b want 0", bus.cpu_stall); end
    endtask

    task automatic test_reset_mid();
        int p0 = pulses;
        int sl;
        bus.cache_en = 1'b1; bus.addr = 32'h0000_0F04; bus.hit_en = 4'b0000; bus.mem_req_ready = 1'b1;
        step();
        bus.cache_en = 1'b0; step();
        bus.mem_req_ready = 1'b0;
        bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h5555_5555; step();
        bus.mem_rdata = 32'h6666_6666; step();
        bus.mem_rdata_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.cpu_stall !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0) begin n_err++; $display("FAIL mid_rst_ctl got stall=%b valid=%b addr=%h want 0", bus.cpu_stall, bus.mem_req_valid, bus.mem_req_addr); end
        n_cmp++; if (bus.refill_line !== 128'h0) begin n_err++; $display("FAIL mid_rst_line got %h want 0", bus.refill_line); end
        n_cmp++; if (bus.addr_to_main_memory !== 32'h0 || bus.refill_cnt !== 16'h0) begin n_err++; $display("FAIL mid_rst_regs got a2m=%h cnt=%h want 0", bus.addr_to_main_memory, bus.refill_cnt); end
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        n_cmp++; if (pulses !== p0) begin n_err++; $display("FAIL mid_rst_pulses got %0d want %0d", pulses, p0); end
        run_refill(32'h0000_0BB0, 128'h99999999_88888888_77777777_12345678, sl);
        n_cmp++; if (bus.refill_line !== 128'h99999999_88888888_77777777_12345678) begin n_err++; $display("FAIL mid_rst_line2 got %h", bus.refill_line); end
        n_cmp++; if (bus.addr_to_main_memory !== 32'h0000_0BB0) begin n_err++; $display("FAIL mid_rst_a2m got %h want 00000BB0", bus.addr_to_main_memory); end
        n_cmp++; if (bus.refill_cnt !== 16'd1) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 1", bus.refill_cnt); end
        n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL mid_rst_pulses2 got %0d want 1", pulses - p0); end
    endtask

    task automatic test_saturation();
        int sl;
        force dut.r_refill_cnt = 16'hFFFE;
        #1;
        release dut.r_refill_cnt;
        #1;
        n_cmp++; if (bus.refill_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_preset got %h want FFFE", bus.refill_cnt); end
        run_refill(32'h0000_2220, 128'h1, sl);
        n_cmp++; if (bus.refill_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach got %h want FFFF", bus.refill_cnt); end
        run_refill(32'h0000_3330, 128'h2, sl);
        n_cmp++; if (bus.refill_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want FFFF", bus.refill_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req_wait_gaps();
        test_lookup_ignored();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
